raw_fetch_sequencer: RTL and testbench
======================================

# raw_fetch_sequencer

Byte-fetch and load sequencer that feeds the raw pixel serializer on the video path. On each active line it reads display bytes from video memory through a request/acknowledge port and buffers them in a 2-entry prefetch FIFO. It presents each byte on `Data` with a one-cycle `Load` strobe at the byte cadence the serializer expects, together with the latched `Mode`, `Css` and `Divider` for that line.

## Interface
Parameters:
- `LINE_BYTES`, 32: bytes emitted per active line; range 1..255.
- `ADDR_W`, 16: video memory address width.

Ports:
- `Clk` in 1: pixel clock. This is the single clock domain.
- `nReset` in 1: asynchronous, active-low reset.
- `Enable` in 1: display enable. When low, the block is forced to idle.
- `LineStart` in 1: one-cycle pulse that starts a line.
- `BaseAddr` in ADDR_W: address of the first byte of the line, sampled on `LineStart`.
- `ModeIn` in 4: host video mode, sampled on `LineStart`.
- `CssIn` in 1: colour set select, sampled on `LineStart`.
- `MemReq` out 1: memory read request.
- `MemAddr` out ADDR_W: read address, valid while `MemReq` is high.
- `MemAck` in 1: read acknowledge. `MemData` is valid in the same cycle.
- `MemData` in 8: read data.
- `Data` out 8: byte to the serializer.
- `Load` out 1: one-cycle strobe. The serializer captures `Data` while `Load` is high.
- `Mode` out 4: line-latched mode to the serializer.
- `Css` out 1: line-latched colour set to the serializer.
- `Divider` out 1: line-latched pixel-rate divider. Equals `ModeIn[0]`.
- `LineDone` out 1: one-cycle pulse, asserted together with the final `Load` of a line.
- `Underrun` out 1: sticky per line. Set if a byte slot occurs while the FIFO is empty.

## Operation
- Reset values (asynchronous): `MemReq`=0, `MemAddr`=0, `Data`=0x00, `Load`=0, `Mode`=0, `Css`=0, `Divider`=0, `LineDone`=0, `Underrun`=0.
  - Internal state on reset: FIFO empty, all counters 0, state IDLE.
- Byte period: P=8 clocks when `Divider`=0, P=16 when `Divider`=1.
- Fetch FSM states: IDLE, FETCH, DRAIN.
  - IDLE → FETCH on `LineStart`. On that edge:
    - address counter ← `BaseAddr`;
    - fetch-remaining ← `LINE_BYTES`; emit-remaining ← `LINE_BYTES`;
    - FIFO flushed; `Underrun` cleared; Running cleared;
    - `Mode`, `Css` and `Divider` latched.
  - FETCH: `MemReq`=1 whenever fetch-remaining>0 and the FIFO is not full. `MemAddr` = address counter.
    - On an edge with `MemReq`&`MemAck`: push `MemData`, increment the address, decrement fetch-remaining.
    - Back-to-back acks are legal.
    - `MemAck` while `MemReq`=0 is ignored.
  - FETCH → DRAIN when fetch-remaining reaches 0.
  - DRAIN → IDLE on the edge that emits the final byte.
- `LineStart` in any state restarts the line: it has the IDLE→FETCH effect and discards all buffered and in-flight work.
- `Enable`=0 forces IDLE, flushes the FIFO and clears Running.
  - `MemReq` is low from the next cycle.
  - `Data`, `Mode`, `Css`, `Divider` and `Underrun` hold their values.
- Emission:
  - Running is set on the edge where the FIFO count becomes 2, or becomes 1 with fetch-remaining=0. At that edge the phase counter is set to 0.
  - While Running, the phase counter counts 0..P-1 and wraps.
  - On each edge with phase=0:
    - `Load`←1 and `Data`←FIFO head (pop).
    - If the FIFO is empty: `Data`←0x00, `Underrun`←1, and `Load` still pulses.
    - Emit-remaining is decremented.
  - `Load` is low on all other edges.
  - When emit-remaining is 1, the same edge also sets `LineDone`←1 and clears Running.
- A push and a pop on the same edge are both performed, and the count is unchanged.
- The address counter wraps modulo 2^ADDR_W.

## Timing
- All outputs are registered.
- With zero-wait memory (`MemAck`=`MemReq`), edges are counted from E0, the edge that samples `LineStart`:
  - `MemReq` is high after E0.
  - Pushes occur at E1 and E2; Running is set at E2.
  - The first `Load` is high after E3, i.e. 3 clocks of latency.
- `Load` k (k=0..LINE_BYTES-1) is high after E3+k·P.
- `LineDone` is coincident with the last `Load`.
- `MemReq` refills the FIFO within one cycle of each pop when memory is zero-wait.
- Memory latency up to P-2 cycles per byte causes no underrun.

## Test plan
- Reset, then `LineStart` with `BaseAddr`=0x0400, `Divider`=0, `LINE_BYTES`=4, zero-wait memory returning data=address[7:0].
  - Required: `MemAddr` sequence 0x0400..0x0403.
  - `Load` after E3, E11, E19, E27 with `Data` 0x00, 0x01, 0x02, 0x03.
  - `LineDone` with the last `Load`; `Underrun`=0.
- Same stimulus with `ModeIn`=4'b0001.
  - Required: `Divider`=1 and `Mode`=1.
  - `Load` after E3, E19, E35, E51.
- `MemAck` delayed 20 cycles on byte 2, `Divider`=0.
  - Required: slot 2 emits `Data`=0x00 and sets `Underrun`=1.
  - Later slots carry the next fetched bytes.
  - `Underrun` clears on the next `LineStart`.
- `BaseAddr`=0xFFFF with `LINE_BYTES`=3.
  - Required: `MemAddr` sequence 0xFFFF, 0x0000, 0x0001.
- Second `LineStart` at E10 of a running line.
  - Required: FIFO flushed.
  - The next `Load` is at E10+3 and carries the first byte of the new `BaseAddr`.
- `Enable` dropped mid-line, and separately `nReset` asserted mid-line.
  - Required: no further `Load` and `MemReq`=0.
  - Reset additionally returns all outputs to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/raw_fetch_sequencer.sv
// raw_fetch_sequencer
//
// Fetches the display bytes of one active line from video memory over a
// request/acknowledge port, buffers them in a 2-entry prefetch FIFO and hands
// them to the raw pixel serializer one byte per byte period. The byte period
// is 8 clocks, or 16 clocks when the line-latched Divider is set.
//
// Ports
//   Clk, nReset      pixel clock, asynchronous active-low reset
//   Enable           display enable; low forces the block idle
//   LineStart        one-cycle pulse that (re)starts a line
//   BaseAddr         address of the first byte of the line (sampled on LineStart)
//   ModeIn, CssIn    host mode / colour set (sampled on LineStart)
//   MemReq, MemAddr  memory read request and address
//   MemAck, MemData  read acknowledge with same-cycle data
//   Data, Load       byte to the serializer and its one-cycle capture strobe
//   Mode, Css        line-latched mode and colour set
//   Divider          line-latched pixel-rate divider (ModeIn[0])
//   LineDone         pulses with the final Load of a line
//   Underrun         sticky per line: a byte slot found the FIFO empty
module raw_fetch_sequencer #(
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Enable,
    input  logic              LineStart,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [3:0]        ModeIn,
    input  logic              CssIn,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemAck,
    input  logic [7:0]        MemData,
    output logic [7:0]        Data,
    output logic              Load,
    output logic [3:0]        Mode,
    output logic              Css,
    output logic              Divider,
    output logic              LineDone,
    output logic              Underrun
);

    localparam logic [7:0] LineBytes = 8'(LINE_BYTES);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        fetch_rem_q, fetch_rem_d;
    logic [7:0]        emit_rem_q, emit_rem_d;
    logic [7:0]        fifo_q [2];
    logic [7:0]        fifo_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              running_q, running_d;
    logic [3:0]        phase_q, phase_d;
    logic              mem_req_q, mem_req_d;
    logic [7:0]        data_q, data_d;
    logic              load_q, load_d;
    logic [3:0]        mode_q, mode_d;
    logic              css_q, css_d;
    logic              div_q, div_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;

    logic              push;
    logic              slot;
    logic              pop;
    logic [3:0]        phase_max;

    assign phase_max = div_q ? 4'd15 : 4'd7;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        fetch_rem_d = fetch_rem_q;
        emit_rem_d  = emit_rem_q;
        fifo_d      = fifo_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        running_d   = running_q;
        phase_d     = phase_q;
        data_d      = data_q;
        load_d      = 1'b0;
        mode_d      = mode_q;
        css_d       = css_q;
        div_d       = div_q;
        done_d      = 1'b0;
        underrun_d  = underrun_q;
        push        = 1'b0;
        slot        = 1'b0;
        pop         = 1'b0;

        if (!Enable) begin
            // Forced idle: drop buffered bytes, keep the serializer-facing values.
            state_d   = StIdle;
            count_d   = 2'd0;
            rd_ptr_d  = 1'b0;
            wr_ptr_d  = 1'b0;
            running_d = 1'b0;
        end else if (LineStart) begin
            // Restart from any state; in-flight acks on this edge are dropped.
            state_d     = StFetch;
            addr_d      = BaseAddr;
            fetch_rem_d = LineBytes;
            emit_rem_d  = LineBytes;
            count_d     = 2'd0;
            rd_ptr_d    = 1'b0;
            wr_ptr_d    = 1'b0;
            underrun_d  = 1'b0;
            running_d   = 1'b0;
            phase_d     = 4'd0;
            mode_d      = ModeIn;
            css_d       = CssIn;
            div_d       = ModeIn[0];
        end else begin
            // mem_req_q is only high in FETCH with room, so an ack here is a valid push.
            push = mem_req_q && MemAck;
            slot = running_q && (phase_q == 4'd0);
            pop  = slot && (count_q != 2'd0);

            if (push) begin
                fifo_d[wr_ptr_q] = MemData;
                wr_ptr_d         = ~wr_ptr_q;
                addr_d           = addr_q + ADDR_W'(1);
                fetch_rem_d      = fetch_rem_q - 8'd1;
            end

            if (running_q) begin
                phase_d = (phase_q == phase_max) ? 4'd0 : phase_q + 4'd1;
            end

            if (state_q == StFetch && fetch_rem_d == 8'd0) begin
                state_d = StDrain;
            end

            if (slot) begin
                load_d     = 1'b1;
                emit_rem_d = emit_rem_q - 8'd1;
                if (pop) begin
                    data_d   = fifo_q[rd_ptr_q];
                    rd_ptr_d = ~rd_ptr_q;
                end else begin
                    // Slot with nothing buffered: still strobe, but with a blank byte.
                    data_d     = 8'h00;
                    underrun_d = 1'b1;
                end
                if (emit_rem_q == 8'd1) begin
                    done_d    = 1'b1;
                    running_d = 1'b0;
                    state_d   = StIdle;
                end
            end

            count_d = count_q + {1'b0, push} - {1'b0, pop};

            // Start emitting once two bytes are buffered, or the last byte of a
            // short line has arrived.
            if (!running_q && state_q != StIdle && emit_rem_q != 8'd0 &&
                (count_d == 2'd2 || (count_d == 2'd1 && fetch_rem_d == 8'd0))) begin
                running_d = 1'b1;
                phase_d   = 4'd0;
            end
        end

        mem_req_d = (state_d == StFetch) && (fetch_rem_d != 8'd0) && (count_d != 2'd2);
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            fetch_rem_q <= 8'd0;
            emit_rem_q  <= 8'd0;
            fifo_q[0]   <= 8'd0;
            fifo_q[1]   <= 8'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            running_q   <= 1'b0;
            phase_q     <= 4'd0;
            mem_req_q   <= 1'b0;
            data_q      <= 8'd0;
            load_q      <= 1'b0;
            mode_q      <= 4'd0;
            css_q       <= 1'b0;
            div_q       <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            fetch_rem_q <= fetch_rem_d;
            emit_rem_q  <= emit_rem_d;
            fifo_q      <= fifo_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            running_q   <= running_d;
            phase_q     <= phase_d;
            mem_req_q   <= mem_req_d;
            data_q      <= data_d;
            load_q      <= load_d;
            mode_q      <= mode_d;
            css_q       <= css_d;
            div_q       <= div_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign MemReq   = mem_req_q;
    assign MemAddr  = addr_q;
    assign Data     = data_q;
    assign Load     = load_q;
    assign Mode     = mode_q;
    assign Css      = css_q;
    assign Divider  = div_q;
    assign LineDone = done_q;
    assign Underrun = underrun_q;

endmodule

// File: tb/tb_raw_fetch_sequencer.sv
// Testbench for raw_fetch_sequencer: directed line scenarios plus randomized
// lines (random base, mode, colour set and memory latency), all checked each
// cycle against a queue-based reference model of the line behaviour.
module tb_raw_fetch_sequencer;

    localparam int unsigned LINE = 4;
    localparam int unsigned AW   = 16;

    logic          Clk = 1'b0;
    logic          nReset;
    logic          Enable;
    logic          LineStart;
    logic [AW-1:0] BaseAddr;
    logic [3:0]    ModeIn;
    logic          CssIn;
    logic          MemReq;
    logic [AW-1:0] MemAddr;
    logic          MemAck;
    logic [7:0]    MemData;
    logic [7:0]    Data;
    logic          Load;
    logic [3:0]    Mode;
    logic          Css;
    logic          Divider;
    logic          LineDone;
    logic          Underrun;

    always #5 Clk = ~Clk;

    raw_fetch_sequencer #(
        .LINE_BYTES(LINE),
        .ADDR_W    (AW)
    ) dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .Enable   (Enable),
        .LineStart(LineStart),
        .BaseAddr (BaseAddr),
        .ModeIn   (ModeIn),
        .CssIn    (CssIn),
        .MemReq   (MemReq),
        .MemAddr  (MemAddr),
        .MemAck   (MemAck),
        .MemData  (MemData),
        .Data     (Data),
        .Load     (Load),
        .Mode     (Mode),
        .Css      (Css),
        .Divider  (Divider),
        .LineDone (LineDone),
        .Underrun (Underrun)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a line is a list of fetched bytes drained one per period.
    int         q_bytes[$];
    int         m_fetched, m_emitted, m_phase, m_period, ecount;
    bit         m_active, m_running, m_req, m_load, m_done, m_under, m_css, m_div;
    logic [7:0] m_data;
    logic [3:0] m_mode;
    logic [15:0] m_addr;

    int lat[LINE];
    int waited;
    int load_edges[$];
    int addr_log[$];
    int first_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q_bytes.delete();
        m_fetched = 0; m_emitted = 0; m_phase = 0; m_period = 8; ecount = 0;
        m_active = 0; m_running = 0; m_req = 0; m_load = 0; m_done = 0; m_under = 0;
        m_css = 0; m_div = 0; m_data = 8'h00; m_mode = 4'h0; m_addr = 16'h0000;
        waited = 0;
    endfunction

    function automatic void model_edge();
        bit ack, was_run, was_active;
        if (!nReset) begin
            model_reset();
            return;
        end
        m_load = 0;
        m_done = 0;
        ack = m_req && MemAck;
        if (!Enable) begin
            m_active = 0; m_running = 0; m_req = 0;
            q_bytes.delete();
            ecount++;
            return;
        end
        if (LineStart) begin
            m_active = 1; m_running = 0; m_under = 0;
            q_bytes.delete();
            m_fetched = 0; m_emitted = 0;
            m_addr = BaseAddr; m_mode = ModeIn; m_css = CssIn; m_div = ModeIn[0];
            m_period = ModeIn[0] ? 16 : 8;
            ecount = 0; waited = 0;
            load_edges.delete(); addr_log.delete();
            m_req = 1;
            return;
        end
        ecount++;
        was_run = m_running;
        was_active = m_active;
        if (m_running) begin
            if (m_phase == 0) begin
                m_load = 1;
                if (q_bytes.size() > 0) m_data = 8'(q_bytes.pop_front());
                else begin
                    m_data = 8'h00;
                    m_under = 1;
                end
                m_emitted++;
                if (m_emitted == LINE) begin
                    m_done = 1; m_running = 0; m_active = 0;
                end
            end
            m_phase = (m_phase + 1) % m_period;
        end
        if (ack) begin
            q_bytes.push_back(int'(MemData));
            m_addr = m_addr + 16'd1;
            m_fetched++;
            waited = 0;
        end
        if (was_active && !was_run && m_emitted < LINE &&
            (q_bytes.size() == 2 || (q_bytes.size() == 1 && m_fetched == LINE))) begin
            m_running = 1;
            m_phase = 0;
        end
        m_req = m_active && (m_fetched < LINE) && (q_bytes.size() < 2);
    endfunction

    task automatic compare();
        chk("Load", Load, m_load);
        chk("LineDone", LineDone, m_done);
        chk("Underrun", Underrun, m_under);
        chk("MemReq", MemReq, m_req);
        if (m_req) chk("MemAddr", MemAddr, m_addr);
        chk("Data", Data, m_data);
        chk("Mode", Mode, m_mode);
        chk("Css", Css, m_css);
        chk("Divider", Divider, m_div);
        if (Load === 1'b1) begin
            if (load_edges.size() == 0) first_data = int'(Data);
            load_edges.push_back(ecount);
        end
    endtask

    // Memory: answers a request after lat[byte] waiting cycles, data = addr[7:0].
    task automatic drive_mem(input bit junk);
        int idx;
        idx = (m_fetched < LINE) ? m_fetched : LINE - 1;
        if (nReset && MemReq === 1'b1) begin
            if (waited >= lat[idx]) begin
                MemAck = 1'b1;
                MemData = MemAddr[7:0];
                addr_log.push_back(int'(MemAddr));
            end else begin
                MemAck = 1'b0;
                MemData = 8'($urandom);
                waited++;
            end
        end else begin
            MemAck = junk && ($urandom_range(0, 3) == 0);
            MemData = 8'($urandom);
        end
    endtask

    task automatic cycle(input bit junk);
        @(posedge Clk);
        model_edge();
        #1;
        compare();
        drive_mem(junk);
        LineStart = 1'b0;
    endtask

    task automatic run(input int n, input bit junk);
        for (int i = 0; i < n; i++) cycle(junk);
    endtask

    task automatic start_line(input logic [15:0] base, input logic [3:0] mode, input logic css,
                              input bit junk);
        BaseAddr = base;
        ModeIn = mode;
        CssIn = css;
        LineStart = 1'b1;
        cycle(junk);
    endtask

    task automatic set_lat(input int v);
        for (int k = 0; k < LINE; k++) lat[k] = v;
    endtask

    task automatic chk_edges(input string tag, input int period);
        chk({tag, "_nloads"}, load_edges.size(), LINE);
        for (int k = 0; k < LINE && k < load_edges.size(); k++)
            chk({tag, "_load_edge"}, load_edges[k], 3 + k * period);
    endtask

    task automatic chk_addrs(input string tag, input logic [15:0] base);
        logic [15:0] a;
        chk({tag, "_nacks"}, addr_log.size(), LINE);
        for (int k = 0; k < LINE && k < addr_log.size(); k++) begin
            a = base + 16'(k);
            chk({tag, "_addr"}, addr_log[k], a);
        end
    endtask

    initial begin
        int n_before;
        int p;
        logic [15:0] rb;
        nReset = 1'b0; Enable = 1'b0; LineStart = 1'b0; BaseAddr = '0; ModeIn = '0;
        CssIn = 1'b0; MemAck = 1'b0; MemData = '0; first_data = 0;
        set_lat(0);
        model_reset();
        #12;
        chk("rst_MemReq", MemReq, 0);
        chk("rst_MemAddr", MemAddr, 0);
        chk("rst_Data", Data, 0);
        chk("rst_Load", Load, 0);
        chk("rst_Mode", Mode, 0);
        chk("rst_Underrun", Underrun, 0);
        nReset = 1'b1;
        Enable = 1'b1;
        run(2, 1'b0);

        // Basic line, Divider=0, zero-wait memory.
        start_line(16'h0400, 4'b0000, 1'b1, 1'b0);
        run(32, 1'b0);
        chk_edges("basic", 8);
        chk_addrs("basic", 16'h0400);
        chk("basic_underrun", Underrun, 0);

        // Divider=1 through ModeIn[0].
        start_line(16'h0400, 4'b0001, 1'b0, 1'b0);
        chk("div_Divider", Divider, 1);
        chk("div_Mode", Mode, 1);
        run(56, 1'b0);
        chk_edges("div", 16);

        // Byte 2 answered 20 cycles late: slot 2 underruns, byte 2 lands in slot 3.
        set_lat(0);
        lat[2] = 20;
        start_line(16'h0400, 4'b0000, 1'b0, 1'b0);
        run(32, 1'b0);
        chk("urun_sticky", Underrun, 1);
        chk("urun_last_data", Data, 8'h02);
        set_lat(0);
        start_line(16'h0500, 4'b0000, 1'b0, 1'b0);
        chk("urun_cleared", Underrun, 0);
        run(32, 1'b0);

        // Address wrap.
        start_line(16'hFFFF, 4'b0000, 1'b0, 1'b0);
        run(32, 1'b0);
        chk_addrs("wrap", 16'hFFFF);

        // Restart at E10 of a running line.
        start_line(16'h1234, 4'b0000, 1'b0, 1'b0);
        run(9, 1'b0);
        start_line(16'h2050, 4'b0000, 1'b0, 1'b0);
        run(32, 1'b0);
        chk("restart_first_edge", load_edges.size() > 0 ? load_edges[0] : -1, 3);
        chk("restart_first_data", first_data, 8'h50);

        // Enable dropped mid-line.
        start_line(16'h3000, 4'b0000, 1'b0, 1'b0);
        run(12, 1'b0);
        Enable = 1'b0;
        n_before = load_edges.size();
        run(24, 1'b0);
        chk("en_no_load", load_edges.size() - n_before, 0);
        chk("en_memreq", MemReq, 0);
        Enable = 1'b1;
        run(20, 1'b0);
        chk("en_still_idle", load_edges.size() - n_before, 0);

        // Reset asserted mid-line, between clock edges.
        start_line(16'h4000, 4'b0101, 1'b1, 1'b0);
        run(14, 1'b0);
        #2 nReset = 1'b0;
        #1;
        chk("arst_Load", Load, 0);
        chk("arst_MemReq", MemReq, 0);
        chk("arst_MemAddr", MemAddr, 0);
        chk("arst_Data", Data, 0);
        chk("arst_Mode", Mode, 0);
        chk("arst_Css", Css, 0);
        chk("arst_Divider", Divider, 0);
        model_reset();
        MemAck = 1'b0;
        run(3, 1'b0);
        nReset = 1'b1;
        n_before = load_edges.size();
        run(30, 1'b0);
        chk("arst_no_load", load_edges.size() - n_before, 0);

        // Randomized lines with memory latency up to P-2 and stray acks.
        for (int l = 0; l < 8; l++) begin
            rb = 16'($urandom);
            ModeIn = 4'($urandom);
            p = ModeIn[0] ? 16 : 8;
            for (int k = 0; k < LINE; k++) lat[k] = $urandom_range(0, p - 2);
            start_line(rb, ModeIn, 1'($urandom), 1'b1);
            run(4 * p + LINE * p, 1'b1);
            chk("rand_nloads", load_edges.size(), LINE);
            chk("rand_no_underrun", Underrun, 0);
            chk_addrs("rand", rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
